// File: rtl/regfile_scoreboard.sv
// Integer register file with bypassed read ports and a per-register pending-write
// scoreboard. Issue reserves a destination register and writeback retires it.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            rd_wr_en,
    input  logic [4:0]      reg_wr_addr,
    input  logic [XLEN-1:0] reg_wr_data,
    output logic            wb_underflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   regs [0:31];
    logic [PEND_W-1:0] pend [0:31];

    logic       issue_fire;
    logic       retire_ok;
    logic       wr_live;
    logic [PEND_W-1:0] rs1_left;
    logic [PEND_W-1:0] rs2_left;

    // A same-cycle retire is deliberately ignored here so issue never depends on writeback.
    assign issue_ready = (issue_rd == 5'd0) || (pend[issue_rd] != PEND_MAX);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
    assign wr_live     = rd_wr_en && (reg_wr_addr != 5'd0);
    assign retire_ok   = wr_live && (pend[reg_wr_addr] != '0);

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wr_live && reg_wr_addr == rs1_addr) rs1_data = reg_wr_data;
        if (wr_live && reg_wr_addr == rs2_addr) rs2_data = reg_wr_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

    // Busy reflects pending writes left after any retire happening this cycle.
    always_comb begin
        rs1_left = pend[rs1_addr];
        rs2_left = pend[rs2_addr];
        if (retire_ok && reg_wr_addr == rs1_addr) rs1_left = rs1_left - 1'b1;
        if (retire_ok && reg_wr_addr == rs2_addr) rs2_left = rs2_left - 1'b1;
        rs1_busy = (rs1_addr != 5'd0) && (rs1_left != '0);
        rs2_busy = (rs2_addr != 5'd0) && (rs2_left != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[reg_wr_addr] <= reg_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue_fire && issue_rd == 5'(r)) begin
                    if (!(retire_ok && reg_wr_addr == 5'(r))) pend[r] <= pend[r] + 1'b1;
                end else if (retire_ok && reg_wr_addr == 5'(r)) begin
                    pend[r] <= pend[r] - 1'b1;
                end
            end
        end
    end

    // Sticky until reset: a retire that had no matching reservation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_underflow <= 1'b0;
        end else if (wr_live && pend[reg_wr_addr] == '0) begin
            wb_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard, checked against an
// array-based reference model of register contents and in-flight write counts.
module tb_regfile_scoreboard;

    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, reg_wr_addr;
    logic [31:0] rs1_data, rs2_data, reg_wr_data;
    logic        rs1_busy, rs2_busy, issue_valid, issue_ready, rd_wr_en, wb_underflow;

    int total = 0;
    int bad = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic        m_under;

    regfile_scoreboard #(.XLEN(32), .PEND_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rd_wr_en(rd_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_under = 1'b0;
    endtask

    function automatic logic [31:0] expData(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (rd_wr_en && reg_wr_addr == a) return reg_wr_data;
        return m_regs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a);
        int left;
        if (a == 0) return 1'b0;
        left = m_pend[a];
        if (rd_wr_en && reg_wr_addr == a && left > 0) left = left - 1;
        return left > 0;
    endfunction

    // Drive one cycle of inputs, check combinational outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input string tag,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input logic iv, input logic [4:0] ird,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic ready_exp;
        rs1_addr = a1; rs2_addr = a2;
        issue_valid = iv; issue_rd = ird;
        rd_wr_en = we; reg_wr_addr = wa; reg_wr_data = wd;
        @(negedge clk);
        ready_exp = (ird == 0) || (m_pend[ird] < PMAX);
        checkOutput({tag, ".rs1_data"}, rs1_data, expData(a1));
        checkOutput({tag, ".rs2_data"}, rs2_data, expData(a2));
        checkOutput({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(expBusy(a1)));
        checkOutput({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(expBusy(a2)));
        checkOutput({tag, ".issue_ready"}, 32'(issue_ready), 32'(ready_exp));
        checkOutput({tag, ".wb_underflow"}, 32'(wb_underflow), 32'(m_under));
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            if (m_pend[wa] == 0) m_under = 1'b1;
            else m_pend[wa] = m_pend[wa] - 1;
        end
        if (iv && ready_exp && ird != 0) m_pend[ird] = m_pend[ird] + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        applyStimulus(tag, a1, a2, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        modelReset();
        reset_n = 1'b0;
        rs1_addr = 0; rs2_addr = 0; issue_valid = 0; issue_rd = 0;
        rd_wr_en = 0; reg_wr_addr = 0; reg_wr_data = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int a = 0; a < 32; a++) idle("reset_read", 5'(a), 5'(31 - a));

        applyStimulus("iss5", 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        idle("busy5", 5'd5, 5'd5);
        idle("wait5", 5'd5, 5'd0);
        applyStimulus("ret5", 5'd5, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        idle("after5", 5'd5, 5'd5);
        checkOutput("x5_stored", rs1_data, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) applyStimulus("iss7", 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus("ret7", 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 32'h700 + 32'(i));
        idle("idle7", 5'd7, 5'd0);
        checkOutput("x7_free", 32'(rs1_busy), 32'd0);

        applyStimulus("iss9", 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        applyStimulus("isret9", 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 32'h9999);
        idle("held9", 5'd9, 5'd9);
        checkOutput("x9_still_busy", 32'(rs1_busy), 32'd1);

        applyStimulus("x0", 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234);
        idle("x0_after", 5'd0, 5'd0);

        applyStimulus("under3", 5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h3333);
        idle("under3_after", 5'd3, 5'd3);
        checkOutput("underflow_set", 32'(wb_underflow), 32'd1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
        end

        for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 5'd2, 5'd4, 1'b1, 5'(2 + 2 * (i % 2)), 1'b0, 5'd0, 32'd0);
        rs1_addr = 5'd2; rs2_addr = 5'd4; issue_rd = 5'd2;
        issue_valid = 1'b0; rd_wr_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst.rs1_data", rs1_data, 32'd0);
        checkOutput("rst.rs1_busy", 32'(rs1_busy), 32'd0);
        checkOutput("rst.rs2_busy", 32'(rs2_busy), 32'd0);
        checkOutput("rst.issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("rst.wb_underflow", 32'(wb_underflow), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            applyStimulus("post_rst",
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
